// File: rtl/decryption_core.sv
//------------------------------------------------------------------------------
// decryption_core : AES-128 inverse cipher, one round per clock, on-the-fly
//                   inverse key expansion from the last encryption round key.
// Revision        : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module decryption_core (
   input  logic         clk_i,
   input  logic         reset_i,
   input  logic         v_i,
   output logic         ready_o,
   input  logic [127:0] data_i,
   input  logic [127:0] key_i,
   output logic         v_o,
   output logic [127:0] data_o,
   input  logic         yumi_i
);

   typedef enum logic [1:0] {IDLE = 2'd0, BUSY = 2'd1, DONE = 2'd2} state_e;

   state_e        fsm_q;
   logic [3:0]    round_q;
   logic [127:0]  state_q;
   logic [127:0]  rk_q;
   logic [127:0]  rk_d;
   logic [127:0]  sub_shift_d;
   logic [127:0]  add_key_d;

   function automatic logic [7:0] xtime(input logic [7:0] b);
      return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
   endfunction

   function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
      logic [7:0] p;
      logic [7:0] x;
      p = 8'h00;
      x = a;
      for (int i = 0; i < 8; i++) begin
         if (b[i]) p = p ^ x;
         x = xtime(x);
      end
      return p;
   endfunction

   // Multiplicative inverse as a^254; maps 0 to 0 as the S-box requires.
   function automatic logic [7:0] ginv(input logic [7:0] a);
      logic [7:0] p;
      logic [7:0] r;
      p = a;
      r = 8'h01;
      for (int i = 0; i < 7; i++) begin
         p = gmul(p, p);
         r = gmul(r, p);
      end
      return r;
   endfunction

   function automatic logic [7:0] rotl8(input logic [7:0] b, input int n);
      return (b << n) | (b >> (8 - n));
   endfunction

   function automatic logic [7:0] sbox(input logic [7:0] x);
      logic [7:0] b;
      b = ginv(x);
      return b ^ rotl8(b, 1) ^ rotl8(b, 2) ^ rotl8(b, 3) ^ rotl8(b, 4) ^ 8'h63;
   endfunction

   function automatic logic [7:0] inv_sbox(input logic [7:0] x);
      return ginv(rotl8(x, 1) ^ rotl8(x, 3) ^ rotl8(x, 6) ^ 8'h05);
   endfunction

   function automatic logic [7:0] rcon(input logic [3:0] r);
      case (r)
         4'd1:    rcon = 8'h01;
         4'd2:    rcon = 8'h02;
         4'd3:    rcon = 8'h04;
         4'd4:    rcon = 8'h08;
         4'd5:    rcon = 8'h10;
         4'd6:    rcon = 8'h20;
         4'd7:    rcon = 8'h40;
         4'd8:    rcon = 8'h80;
         4'd9:    rcon = 8'h1b;
         4'd10:   rcon = 8'h36;
         default: rcon = 8'h00;
      endcase
   endfunction

   // Undo one step of the forward schedule: rk_{r-1} from rk_r using Rcon[r].
   function automatic logic [127:0] inv_expand(input logic [127:0] rk, input logic [7:0] rc);
      logic [31:0] w0, w1, w2, w3;
      logic [31:0] rot;
      w3  = rk[31:0]   ^ rk[63:32];
      w2  = rk[63:32]  ^ rk[95:64];
      w1  = rk[95:64]  ^ rk[127:96];
      rot = {w3[23:0], w3[31:24]};
      w0  = rk[127:96] ^ {sbox(rot[31:24]), sbox(rot[23:16]), sbox(rot[15:8]), sbox(rot[7:0])}
                       ^ {rc, 24'h000000};
      return {w0, w1, w2, w3};
   endfunction

   // Byte k of the state (column-major) sits at [127-8k -: 8].
   function automatic logic [127:0] inv_shift_sub(input logic [127:0] s);
      logic [127:0] o;
      o = '0;
      for (int c = 0; c < 4; c++) begin
         for (int r = 0; r < 4; r++) begin
            o[127 - 8*(4*c + r) -: 8] = inv_sbox(s[127 - 8*(4*((c - r + 4) % 4) + r) -: 8]);
         end
      end
      return o;
   endfunction

   function automatic logic [127:0] inv_mix_columns(input logic [127:0] s);
      logic [127:0] o;
      logic [7:0]   a0, a1, a2, a3;
      o = '0;
      for (int c = 0; c < 4; c++) begin
         a0 = s[127 - 32*c -: 8];
         a1 = s[119 - 32*c -: 8];
         a2 = s[111 - 32*c -: 8];
         a3 = s[103 - 32*c -: 8];
         o[127 - 32*c -: 8] = gmul(a0, 8'h0e) ^ gmul(a1, 8'h0b) ^ gmul(a2, 8'h0d) ^ gmul(a3, 8'h09);
         o[119 - 32*c -: 8] = gmul(a0, 8'h09) ^ gmul(a1, 8'h0e) ^ gmul(a2, 8'h0b) ^ gmul(a3, 8'h0d);
         o[111 - 32*c -: 8] = gmul(a0, 8'h0d) ^ gmul(a1, 8'h09) ^ gmul(a2, 8'h0e) ^ gmul(a3, 8'h0b);
         o[103 - 32*c -: 8] = gmul(a0, 8'h0b) ^ gmul(a1, 8'h0d) ^ gmul(a2, 8'h09) ^ gmul(a3, 8'h0e);
      end
      return o;
   endfunction

   // rk_q holds rk_{r+1} during round r, so the key for this round is one step back.
   assign rk_d        = inv_expand(rk_q, rcon(round_q + 4'd1));
   assign sub_shift_d = inv_shift_sub(state_q);
   assign add_key_d   = sub_shift_d ^ rk_d;

   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         fsm_q   <= IDLE;
         round_q <= 4'd0;
         state_q <= '0;
         rk_q    <= '0;
      end else begin
         case (fsm_q)
            IDLE: begin
               if (v_i) begin
                  state_q <= data_i ^ key_i;
                  rk_q    <= key_i;
                  round_q <= 4'd9;
                  fsm_q   <= BUSY;
               end
            end
            BUSY: begin
               rk_q <= rk_d;
               if (round_q == 4'd0) begin
                  state_q <= add_key_d;
                  fsm_q   <= DONE;
               end else begin
                  state_q <= inv_mix_columns(add_key_d);
                  round_q <= round_q - 4'd1;
               end
            end
            DONE: begin
               if (yumi_i) fsm_q <= IDLE;
            end
            default: fsm_q <= IDLE;
         endcase
      end
   end

   assign ready_o = (fsm_q == IDLE) && !reset_i;
   assign v_o     = (fsm_q == DONE);
   assign data_o  = state_q;

endmodule

`default_nettype wire

// File: tb/tb_decryption_core.sv
//------------------------------------------------------------------------------
// tb_decryption_core : directed vectors with a queue-based scoreboard monitor.
// Revision           : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module tb_decryption_core;

   logic         clk_i;
   logic         reset_i;
   logic         v_i;
   logic         ready_o;
   logic [127:0] data_i;
   logic [127:0] key_i;
   logic         v_o;
   logic [127:0] data_o;
   logic         yumi_i;

   typedef struct {
      logic [127:0] pt;
      int           acc;
   } exp_t;

   exp_t q[$];
   int   checks;
   int   errors;
   int   cyc;
   bit   yumi_en;
   bit   force_yumi;
   bit   v_seen;
   bit   ready_chk;

   localparam logic [127:0] C1_CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
   localparam logic [127:0] C1_KEY = 128'h13111d7fe3944a17f307a78b4d2b30c5;
   localparam logic [127:0] C1_PT  = 128'h00112233445566778899aabbccddeeff;
   localparam logic [127:0] B_CT   = 128'h3925841d02dc09fbdc118597196a0b32;
   localparam logic [127:0] B_KEY  = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
   localparam logic [127:0] B_PT   = 128'h3243f6a8885a308d313198a2e0370734;

   logic [127:0] ecb_ct [4];
   logic [127:0] ecb_pt [4];

   decryption_core dut (
      .clk_i   (clk_i),
      .reset_i (reset_i),
      .v_i     (v_i),
      .ready_o (ready_o),
      .data_i  (data_i),
      .key_i   (key_i),
      .v_o     (v_o),
      .data_o  (data_o),
      .yumi_i  (yumi_i)
   );

   initial begin
      clk_i = 1'b0;
      forever #5 clk_i = ~clk_i;
   end

   always @(posedge clk_i) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Monitor: latency on first sight of v_o, data check and pop on consume.
   always @(negedge clk_i) begin
      yumi_i = force_yumi;
      if (ready_chk) begin
         ready_chk = 1'b0;
         chk("ready_after_yumi", {127'd0, ready_o}, 128'd1);
      end
      if (v_o && !reset_i) begin
         if (!v_seen) begin
            v_seen = 1'b1;
            if (q.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL unexpected_output: got %h with empty scoreboard", data_o);
            end else begin
               chk("latency", 128'(cyc), 128'(q[0].acc + 11));
            end
         end
         if (yumi_en) begin
            if (q.size() > 0) begin
               chk("plaintext", data_o, q[0].pt);
               void'(q.pop_front());
            end
            yumi_i    = 1'b1;
            v_seen    = 1'b0;
            ready_chk = 1'b1;
         end
      end
   end

   task automatic send(input logic [127:0] ct, input logic [127:0] key,
                       input logic [127:0] pt, output int acc);
      int n;
      n      = 0;
      acc    = -1;
      v_i    = 1'b1;
      data_i = ct;
      key_i  = key;
      while (!(ready_o && !reset_i) && n < 100) begin
         @(negedge clk_i);
         n++;
      end
      if (n >= 100) begin
         checks++;
         errors++;
         $display("FAIL accept_timeout: got ready_o=%b expected 1 within 100 cycles", ready_o);
      end else begin
         acc = cyc;
         q.push_back('{pt, cyc});
         @(negedge clk_i);
      end
      v_i = 1'b0;
   endtask

   task automatic drain();
      int n;
      n = 0;
      while (q.size() > 0 && n < 200) begin
         @(negedge clk_i);
         n++;
      end
      if (q.size() > 0) begin
         checks++;
         errors++;
         $display("FAIL drain_timeout: got %0d pending expected 0", q.size());
         q.delete();
      end
   endtask

   initial begin
      int a0, a1;
      int n;
      ecb_ct[0] = 128'h3ad77bb40d7a3660a89ecaf32466ef97;
      ecb_pt[0] = 128'h6bc1bee22e409f96e93d7e117393172a;
      ecb_ct[1] = 128'hf5d3d58503b9699de785895a96fdbaaf;
      ecb_pt[1] = 128'hae2d8a571e03ac9c9eb76fac45af8e51;
      ecb_ct[2] = 128'h43b1cd7f598ece23881b00e3ed030688;
      ecb_pt[2] = 128'h30c81c46a35ce411e5fbc1191a0a52ef;
      ecb_ct[3] = 128'h7b0c785e27e8ad3f8223207104725dd4;
      ecb_pt[3] = 128'hf69f2445df4f9b17ad2b417be66c3710;

      checks = 0; errors = 0; cyc = 0;
      yumi_en = 1'b1; force_yumi = 1'b0; v_seen = 1'b0; ready_chk = 1'b0;
      reset_i = 1'b1; v_i = 1'b0; data_i = '0; key_i = '0; yumi_i = 1'b0;

      repeat (3) @(negedge clk_i);
      chk("reset_v_o",     {127'd0, v_o},     128'd0);
      chk("reset_data_o",  data_o,            128'd0);
      chk("reset_ready_o", {127'd0, ready_o}, 128'd0);
      reset_i = 1'b0;
      @(negedge clk_i);
      chk("ready_after_reset", {127'd0, ready_o}, 128'd1);

      send(C1_CT, C1_KEY, C1_PT, a0);
      drain();

      // Stray yumi while busy must not disturb the block.
      send(B_CT, B_KEY, B_PT, a0);
      force_yumi = 1'b1;
      repeat (3) @(negedge clk_i);
      force_yumi = 1'b0;
      drain();

      // Back-to-back with v_i held high: one block every 12 cycles.
      send(ecb_ct[0], B_KEY, ecb_pt[0], a0);
      for (int i = 1; i < 4; i++) begin
         send(ecb_ct[i], B_KEY, ecb_pt[i], a1);
         chk("b2b_spacing", 128'(a1 - a0), 128'd12);
         a0 = a1;
      end
      drain();

      // Backpressure: result held, ready low, v_i pulses ignored.
      yumi_en = 1'b0;
      send(C1_CT, C1_KEY, C1_PT, a0);
      n = 0;
      while (!v_o && n < 50) begin
         @(negedge clk_i);
         n++;
      end
      chk("bp_v_o_seen", {127'd0, v_o}, 128'd1);
      for (int i = 0; i < 20; i++) begin
         @(negedge clk_i);
         chk("bp_data_stable", data_o,            C1_PT);
         chk("bp_v_o_held",    {127'd0, v_o},     128'd1);
         chk("bp_ready_low",   {127'd0, ready_o}, 128'd0);
         v_i    = i[0];
         data_i = {$urandom, $urandom, $urandom, $urandom};
         key_i  = {$urandom, $urandom, $urandom, $urandom};
      end
      v_i = 1'b0;
      yumi_en = 1'b1;
      drain();

      // Reset while round 5 is in the state register aborts the block.
      send(C1_CT, C1_KEY, C1_PT, a0);
      repeat (4) @(negedge clk_i);
      reset_i = 1'b1;
      q.delete();
      @(negedge clk_i);
      chk("abort_v_o",     {127'd0, v_o},     128'd0);
      chk("abort_data_o",  data_o,            128'd0);
      chk("abort_ready_o", {127'd0, ready_o}, 128'd0);
      reset_i = 1'b0;
      v_seen  = 1'b0;
      @(negedge clk_i);
      chk("abort_ready_after", {127'd0, ready_o}, 128'd1);
      chk("abort_v_o_after",   {127'd0, v_o},     128'd0);
      send(C1_CT, C1_KEY, C1_PT, a0);
      drain();

      repeat (3) @(negedge clk_i);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog expired");
   end

endmodule

`default_nettype wire
